// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter between inert_intf and A2D_intf.
package spi_arb_pkg;

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;
   typedef enum logic {INERT, A2D} owner_t;

   localparam logic [15:0] ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/spi_bus_arb_req_slot.sv
// One-deep request slot: captures a pulsed request and its command until granted.
module req_slot (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] cmd,
   input  logic        grant,
   output logic        pending,
   output logic [15:0] cmd_q,
   output logic        ovr
);

   // A grant wins over a simultaneous wrt, so that pulse is lost without flagging overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         cmd_q   <= 16'h0000;
         ovr     <= 1'b0;
      end else if (grant) begin
         pending <= 1'b0;
      end else if (wrt) begin
         if (pending) begin
            ovr <= 1'b1;
         end else begin
            pending <= 1'b1;
            cmd_q   <= cmd;
         end
      end
   end

endmodule

// File: rtl/spi_bus_arb.sv
// Shares one SPI master between the inertial and A2D interfaces with fixed priority,
// an A2D starvation guard and a watchdog that aborts hung transfers.
module spi_bus_arb
   import spi_arb_pkg::*;
#(
   parameter int MAX_STREAK = 4,
   parameter int TMO_CYC    = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inert_wrt,
   input  logic [15:0] inert_cmd,
   output logic        inert_done,
   output logic [15:0] inert_rd_data,
   input  logic        a2d_wrt,
   input  logic [15:0] a2d_cmd,
   output logic        a2d_done,
   output logic [15:0] a2d_rd_data,
   output logic        m_wrt,
   output logic [15:0] m_cmd,
   input  logic        m_done,
   input  logic [15:0] m_rd_data,
   input  logic        m_SS_n,
   output logic        INERT_SS_n,
   output logic        A2D_SS_n,
   output logic [1:0]  ovr_err,
   output logic        tmo_err
);

   localparam int TMR_W = $clog2(TMO_CYC);
   localparam int STR_W = $clog2(MAX_STREAK + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_CYC - 1);
   localparam logic [STR_W-1:0] STR_MAX  = STR_W'(MAX_STREAK);

   state_t            state_reg;
   owner_t            owner_reg;
   logic [TMR_W-1:0]  timer_reg;
   logic [STR_W-1:0]  streak_reg;

   logic        inert_pend, a2d_pend;
   logic [15:0] inert_cmd_q, a2d_cmd_q;
   logic        inert_ovr, a2d_ovr;
   logic        pick_a2d, grant_inert, grant_a2d;
   logic        xfer_end;
   logic [15:0] end_data;

   req_slot u_inert_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt     (inert_wrt),
      .cmd     (inert_cmd),
      .grant   (grant_inert),
      .pending (inert_pend),
      .cmd_q   (inert_cmd_q),
      .ovr     (inert_ovr)
   );

   req_slot u_a2d_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt     (a2d_wrt),
      .cmd     (a2d_cmd),
      .grant   (grant_a2d),
      .pending (a2d_pend),
      .cmd_q   (a2d_cmd_q),
      .ovr     (a2d_ovr)
   );

   // A2D only overtakes a pending inertial request once the streak has saturated.
   assign pick_a2d    = a2d_pend && (!inert_pend || (streak_reg == STR_MAX));
   assign grant_a2d   = (state_reg == IDLE) && pick_a2d;
   assign grant_inert = (state_reg == IDLE) && inert_pend && !pick_a2d;

   // m_done takes precedence over a timeout landing on the same cycle.
   assign xfer_end = m_done || (timer_reg == TMR_LAST);
   assign end_data = m_done ? m_rd_data : ERR_DATA;

   assign ovr_err    = {a2d_ovr, inert_ovr};
   assign INERT_SS_n = (owner_reg == INERT) ? m_SS_n : 1'b1;
   assign A2D_SS_n   = (owner_reg == A2D)   ? m_SS_n : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         owner_reg     <= INERT;
         timer_reg     <= '0;
         streak_reg    <= '0;
         m_wrt         <= 1'b0;
         m_cmd         <= 16'h0000;
         inert_done    <= 1'b0;
         a2d_done      <= 1'b0;
         inert_rd_data <= 16'h0000;
         a2d_rd_data   <= 16'h0000;
         tmo_err       <= 1'b0;
      end else begin
         m_wrt      <= 1'b0;
         inert_done <= 1'b0;
         a2d_done   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_a2d) begin
                  state_reg  <= LAUNCH;
                  owner_reg  <= A2D;
                  m_cmd      <= a2d_cmd_q;
                  m_wrt      <= 1'b1;
                  streak_reg <= '0;
               end else if (grant_inert) begin
                  state_reg <= LAUNCH;
                  owner_reg <= INERT;
                  m_cmd     <= inert_cmd_q;
                  m_wrt     <= 1'b1;
                  if (a2d_pend && (streak_reg != STR_MAX))
                     streak_reg <= streak_reg + STR_W'(1);
               end
            end
            LAUNCH: begin
               state_reg <= BUSY;
               timer_reg <= '0;
            end
            BUSY: begin
               if (xfer_end) begin
                  state_reg <= IDLE;
                  if (!m_done)
                     tmo_err <= 1'b1;
                  if (owner_reg == INERT) begin
                     inert_rd_data <= end_data;
                     inert_done    <= 1'b1;
                  end else begin
                     a2d_rd_data <= end_data;
                     a2d_done    <= 1'b1;
                  end
               end else begin
                  timer_reg <= timer_reg + TMR_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
